alu_rs_scheduler: RTL and testbench

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

---
 rtl/alu_rs_scheduler_pkg.sv | 14 +
 rtl/alu_rs_scheduler_if.sv | 34 +++
 rtl/alu_rs_scheduler_age_matrix.sv | 60 ++++++
 rtl/alu_rs_scheduler.sv | 100 ++++++++++
 tb/tb_alu_rs_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared core constants and types for the ALU reservation station scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_rs_scheduler_pkg;

  localparam int RS_ENTRIES = 4;  // ALU reservation station depth (power of two, 2..8)
  localparam int RS_CNT_W   = 2;  // occupancy counter is RS_CNT_W+1 bits wide
  localparam int ROB_TAG_W  = 6;  // reorder buffer tag width used by the rest of the core

  // Entry index; sized from RS_ENTRIES, so a scheduler built with a different
  // ENTRIES value must also change RS_ENTRIES here.
  typedef logic [$clog2(RS_ENTRIES)-1:0] rs_idx_t;

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch/issue handshake bundle between rename, the ALU RS entries and the scheduler.
// Latency: n/a (wires only).
// Backpressure: dispatchReady throttles rename; aluReady throttles issue.
// Ports: master = rename/ALU side (drives flush, dispatchValid, selectReq, aluReady);
//        slave  = scheduler (drives dispatchReady, writeReq, selected, execute, clear, occupancy).
interface alu_rs_scheduler_if
  import alu_rs_scheduler_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int CNT_W   = RS_CNT_W
) ();

  logic               flush;
  logic               dispatchValid;
  logic               dispatchReady;
  logic [ENTRIES-1:0] writeReq;
  logic [ENTRIES-1:0] selectReq;
  logic               aluReady;
  logic [ENTRIES-1:0] selected;
  logic               execute;
  logic               clear;
  logic [CNT_W:0]     occupancy;

  modport master (
    output flush, dispatchValid, selectReq, aluReady,
    input  dispatchReady, writeReq, selected, execute, clear, occupancy
  );

  modport slave (
    input  flush, dispatchValid, selectReq, aluReady,
    output dispatchReady, writeReq, selected, execute, clear, occupancy
  );

endinterface

// File: rtl/alu_rs_scheduler_age_matrix.sv
// Age matrix over RS entries plus combinational oldest-eligible pick.
// Latency: grant is combinational from eligible; matrix updates on the next posedge.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: clk_i, reset_i (sync, high), flush_i, occupied_i (registered occupancy),
//        alloc_i (one-hot allocation), eligible_i, grant_o (one-hot oldest eligible).
module rs_age_matrix #(
  parameter int ENTRIES = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic [ENTRIES-1:0] occupied_i,
  input  logic [ENTRIES-1:0] alloc_i,
  input  logic [ENTRIES-1:0] eligible_i,
  output logic [ENTRIES-1:0] grant_o
);

  // older_q[i][j] = 1: entry i was allocated before entry j.
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;

  // A new entry is younger than everything currently resident: its column is
  // rewritten from occupancy and its row cleared. Stale rows of freed entries
  // never matter because only occupied entries can be eligible.
  always_comb begin
    older_d = older_q;
    if (flush_i) begin
      older_d = '0;
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (alloc_i[k]) begin
          for (int j = 0; j < ENTRIES; j++) begin
            older_d[j][k] = occupied_i[j];
            older_d[k][j] = 1'b0;
          end
        end
      end
    end
  end

  // Occupied entries form a total order, so exactly one eligible entry has no
  // older eligible peer.
  always_comb begin : pick
    logic blocked;
    blocked = 1'b0;
    grant_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES; j++) begin
        if (eligible_i[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (eligible_i[i] && !blocked) grant_o[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) older_q <= '0;
    else         older_q <= older_d;
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station scheduler: free-slot allocation, oldest-first issue, occupancy, flush.
// Latency: writeReq/selected/execute combinational in the request cycle; state updates next posedge.
// Backpressure: dispatchReady low when full, flushing or in reset; no issue without aluReady.
// Ports: clk, reset (sync, high), rs (slave side of alu_rs_scheduler_if).
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES,
  parameter int CNT_W   = RS_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_rs_scheduler_if.slave     rs
);

  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(ENTRIES);
  localparam logic [CNT_W:0] ONE  = (CNT_W+1)'(1);

  logic [ENTRIES-1:0] occupied_q, occupied_d;
  logic [CNT_W:0]     occupancy_q, occupancy_d;
  logic               kill;
  logic               alloc, issue;
  logic               free_found;
  rs_idx_t            free_idx;
  logic [ENTRIES-1:0] alloc_oh, eligible, grant, issue_oh;

  // Reset and flush both squash every request in the same cycle.
  assign kill = reset | rs.flush;

  // Ready comes from registered occupancy only; a slot freed by this cycle's
  // issue is not offered until the next cycle.
  assign rs.dispatchReady = !kill && (occupancy_q < FULL);

  // Lowest-index free slot: scan high to low so the last hit wins.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!occupied_q[i]) begin
        free_idx   = rs_idx_t'(i);
        free_found = 1'b1;
      end
    end
  end

  assign alloc = rs.dispatchValid && rs.dispatchReady && free_found;

  always_comb begin
    alloc_oh = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_oh[i] = alloc && (free_idx == rs_idx_t'(i));
    end
  end

  // Uses registered occupancy, so an entry written this cycle cannot issue yet.
  assign eligible = occupied_q & rs.selectReq;

  rs_age_matrix #(.ENTRIES(ENTRIES)) u_age (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (rs.flush),
    .occupied_i (occupied_q),
    .alloc_i    (alloc_oh),
    .eligible_i (eligible),
    .grant_o    (grant)
  );

  assign issue    = rs.aluReady && !kill && (|eligible);
  assign issue_oh = issue ? grant : '0;

  assign rs.writeReq  = alloc_oh;
  assign rs.selected  = issue_oh;
  assign rs.execute   = issue;
  assign rs.clear     = kill;
  assign rs.occupancy = occupancy_q;

  always_comb begin
    occupied_d  = (occupied_q & ~issue_oh) | alloc_oh;
    occupancy_d = occupancy_q;
    if (rs.flush) begin
      occupied_d  = '0;
      occupancy_d = '0;
    end else if (alloc && !issue) begin
      occupancy_d = occupancy_q + ONE;
    end else if (issue && !alloc) begin
      occupancy_d = occupancy_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupied_q  <= '0;
      occupancy_q <= '0;
    end else begin
      occupied_q  <= occupied_d;
      occupancy_q <= occupancy_d;
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: fixed vector table, directed corner sequences,
// then randomized traffic against an allocation-order queue model.
// Ports: none (top-level bench).
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_rs_scheduler_if #(.ENTRIES(N), .CNT_W(2)) bus ();

  alu_rs_scheduler #(.ENTRIES(N), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: resident entry ids, oldest first.
  int q[$];

  // Outputs captured mid-cycle by cyc().
  logic [3:0] s_wr, s_sel;
  logic       s_exec, s_rdy, s_clr;
  logic [2:0] s_occ;

  typedef struct {
    logic       fl;
    logic       dv;
    logic [3:0] sr;
    logic       ar;
    logic [3:0] wr;
    logic [3:0] sel;
    logic [2:0] occ;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic fl, input logic dv, input logic [3:0] sr,
                              input logic ar, input logic [3:0] wr, input logic [3:0] sel,
                              input logic [2:0] occ, input logic rdy);
    vec_t v;
    v.fl = fl; v.dv = dv; v.sr = sr; v.ar = ar;
    v.wr = wr; v.sel = sel; v.occ = occ; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic cyc(input logic rst, input logic fl, input logic dv,
                     input logic [3:0] sr, input logic ar);
    logic [3:0] mask, e_wr, e_sel;
    logic       e_rdy;
    int         cnt;
    @(negedge clk);
    reset             = rst;
    bus.flush         = fl;
    bus.dispatchValid = dv;
    bus.selectReq     = sr;
    bus.aluReady      = ar;
    #2;
    mask = '0;
    for (int k = 0; k < q.size(); k++) mask[q[k]] = 1'b1;
    cnt   = q.size();
    e_rdy = !rst && !fl && (cnt < N);
    e_wr  = '0;
    if (dv && e_rdy) begin
      for (int i = 0; i < N; i++) begin
        if (!mask[i]) begin
          e_wr[i] = 1'b1;
          break;
        end
      end
    end
    e_sel = '0;
    if (!rst && !fl && ar) begin
      for (int k = 0; k < q.size(); k++) begin
        if (sr[q[k]]) begin
          e_sel[q[k]] = 1'b1;
          break;
        end
      end
    end
    s_wr = bus.writeReq; s_sel = bus.selected; s_exec = bus.execute;
    s_rdy = bus.dispatchReady; s_clr = bus.clear; s_occ = bus.occupancy;
    chk("m_wr",   8'(s_wr),   8'(e_wr));
    chk("m_sel",  8'(s_sel),  8'(e_sel));
    chk("m_exec", 8'(s_exec), 8'(|e_sel));
    chk("m_rdy",  8'(s_rdy),  8'(e_rdy));
    chk("m_clr",  8'(s_clr),  8'(rst | fl));
    chk("m_occ",  8'(s_occ),  8'(cnt));
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
    end else begin
      for (int k = 0; k < q.size(); k++) begin
        if (e_sel[q[k]]) begin
          q.delete(k);
          break;
        end
      end
      for (int i = 0; i < N; i++) if (e_wr[i]) q.push_back(i);
    end
  endtask

  task automatic expect_cur(input string tag, input logic [3:0] wr, input logic [3:0] sel,
                            input logic [2:0] occ, input logic rdy, input logic clr);
    chk({tag, "_wr"},   8'(s_wr),   8'(wr));
    chk({tag, "_sel"},  8'(s_sel),  8'(sel));
    chk({tag, "_exec"}, 8'(s_exec), 8'(|sel));
    chk({tag, "_occ"},  8'(s_occ),  8'(occ));
    chk({tag, "_rdy"},  8'(s_rdy),  8'(rdy));
    chk({tag, "_clr"},  8'(s_clr),  8'(clr));
  endtask

  initial begin
    bus.flush = 1'b0; bus.dispatchValid = 1'b0; bus.selectReq = '0; bus.aluReady = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with requests pending: everything suppressed, clear asserted.
    cyc(1'b1, 1'b0, 1'b1, 4'hF, 1'b1);
    expect_cur("rst", 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1);

    // fl dv sr ar | wr sel occ rdy
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0001, 4'b0000, 3'd0, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 3'd1, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0100, 4'b0000, 3'd2, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b1000, 4'b0000, 3'd3, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd4, 0));
    tbl.push_back(mk(1, 1, 4'b1111, 1, 4'b0000, 4'b0000, 3'd4, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0, 1));
    // Build allocation order 2,0,3,1 through lowest-free picks.
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0001, 4'b0000, 3'd0, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 3'd1, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0100, 4'b0000, 3'd2, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b1000, 4'b0000, 3'd3, 1));
    tbl.push_back(mk(0, 0, 4'b1001, 1, 4'b0000, 4'b0001, 3'd4, 0));
    tbl.push_back(mk(0, 0, 4'b1001, 1, 4'b0000, 4'b1000, 3'd3, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0001, 4'b0000, 3'd2, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b1000, 4'b0000, 3'd3, 1));
    tbl.push_back(mk(0, 0, 4'b0010, 1, 4'b0000, 4'b0010, 3'd4, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 3'd3, 1));
    // All requesting: issue strictly by age 2,0,3,1.
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 4'b0100, 3'd4, 0));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 4'b0001, 3'd3, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 4'b1000, 3'd2, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 4'b0010, 3'd1, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 4'b0000, 3'd0, 1));

    foreach (tbl[n]) begin
      cyc(1'b0, tbl[n].fl, tbl[n].dv, tbl[n].sr, tbl[n].ar);
      expect_cur($sformatf("tbl%0d", n), tbl[n].wr, tbl[n].sel, tbl[n].occ, tbl[n].rdy, tbl[n].fl);
    end

    // Entry written this cycle is not eligible until the next one.
    cyc(1'b0, 1'b0, 1'b1, 4'b0001, 1'b1);
    expect_cur("same_wr", 4'b0001, 4'b0000, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'b0001, 1'b1);
    expect_cur("next_sel", 4'b0000, 4'b0001, 3'd1, 1'b1, 1'b0);

    // Full RS: issue entry 1 while dispatching; the freed slot is taken one cycle later.
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 4'b0010, 1'b1);
    expect_cur("full_iss", 4'b0000, 4'b0010, 3'd4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    expect_cur("refill", 4'b0010, 4'b0000, 3'd3, 1'b1, 1'b0);

    // ALU stalled: nothing issues, occupancy holds.
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
      expect_cur($sformatf("stall%0d", c), 4'b0000, 4'b0000, 3'd4, 1'b0, 1'b0);
    end

    // Age order now 0,2,3,1: oldest is 0. Then flush at occupancy 3.
    cyc(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    expect_cur("pre_fl", 4'b0000, 4'b0001, 3'd4, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    expect_cur("flush", 4'b0000, 4'b0000, 3'd3, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    expect_cur("post_fl", 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0);

    // Reset mid-operation beats dispatch and issue.
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'b1111, 1'b1);
    expect_cur("mid_rst", 4'b0000, 4'b0000, 3'd2, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    expect_cur("post_rst", 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0);

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      cyc(($urandom % 97) == 0, ($urandom % 23) == 0, ($urandom % 3) != 0,
          4'($urandom), ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
